// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: D = A - B - BIN computed DIGIT bits per clock,
// with a registered borrow between slices and valid/ready handshakes.
module seq_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = $clog2(NSTEP + 1);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] d_next;
    logic             borrow;
    logic [CW-1:0]    step;
    logic             last_step;
    logic [DIGIT-1:0] diff;
    logic             brw;
    int               base;

    // One slice of the ripple: borrow-extended subtraction of the current digit.
    always_comb begin
        base      = int'(step) * DIGIT;
        last_step = (step == CW'(NSTEP - 1));
        {brw, diff} = {1'b0, a_reg[base +: DIGIT]} - {1'b0, b_reg[base +: DIGIT]}
                    - {{DIGIT{1'b0}}, borrow};
        d_next = d;
        d_next[base +: DIGIT] = diff;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Overflow uses the fully assembled result, so it is taken from d_next on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            step   <= '0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= bin;
                        step   <= '0;
                    end
                end
                RUN: begin
                    d      <= d_next;
                    borrow <= brw;
                    step   <= step + 1'b1;
                    if (last_step) begin
                        bout <= brw;
                        ovf  <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (d_next[WIDTH-1] ^ a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_subtractor.sv
// Randomised self-checking bench for seq_subtractor (W=8/D=1 and W=16/D=4 instances)
// against a plain-arithmetic reference model.
module tb_seq_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv [2];
    logic        ir [2];
    logic [15:0] av [2];
    logic [15:0] bv [2];
    logic        binv [2];
    logic        ovv [2];
    logic        orv [2];
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        bo [2];
    logic        of [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .bin(binv[0]), .out_valid(ovv[0]),
        .out_ready(orv[0]), .d(d8), .bout(bo[0]), .ovf(of[0])
    );

    seq_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .bin(binv[1]), .out_valid(ovv[1]),
        .out_ready(orv[1]), .d(d16), .bout(bo[1]), .ovf(of[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] getD(input int w);
        return (w == 0) ? {8'h00, d8} : d16;
    endfunction

    function automatic int widthOf(input int w);
        return (w == 0) ? 8 : 16;
    endfunction

    function automatic int nstepOf(input int w);
        return (w == 0) ? 8 : 4;
    endfunction

    // Reference: integer subtraction, borrow from sign of the unsigned result,
    // overflow from range of the signed result.
    function automatic void model(input int wd, input logic [15:0] x, input logic [15:0] y,
                                  input logic c, output logic [15:0] ed,
                                  output logic eb, output logic eo);
        int ux, uy, r, sx, sy, sr, half, full;
        half = 1 << (wd - 1);
        full = 1 << wd;
        ux = int'(x);
        uy = int'(y);
        r  = ux - uy - int'(c);
        eb = (r < 0);
        ed = 16'(r & (full - 1));
        sx = (ux >= half) ? ux - full : ux;
        sy = (uy >= half) ? uy - full : uy;
        sr = sx - sy - int'(c);
        eo = (sr < -half) || (sr > half - 1);
    endfunction

    task automatic applyStimulus(input int w, input logic [15:0] xi, input logic [15:0] yi,
                                 input logic c, input int hold, input bit poke);
        int cnt;
        logic [15:0] x, y, ed;
        logic eb, eo;
        x = xi;
        y = yi;
        if (w == 0) begin
            x[15:8] = 8'h00;
            y[15:8] = 8'h00;
        end
        model(widthOf(w), x, y, c, ed, eb, eo);
        cnt = 0;
        while (!ir[w] && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!ir[w]) begin
            checkOutput("in_ready_timeout", 32'(ir[w]), 32'd1);
            return;
        end
        iv[w] = 1'b1; av[w] = x; bv[w] = y; binv[w] = c;
        @(posedge clk); #1;
        iv[w] = 1'b0; av[w] = 16'($urandom); bv[w] = 16'($urandom); binv[w] = 1'($urandom);
        cnt = 0;
        while (!ovv[w] && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("latency", 32'(cnt), 32'(nstepOf(w)));
        if (!ovv[w]) return;
        for (int i = 0; i < hold; i++) begin
            orv[w] = 1'b0;
            if (poke) begin
                iv[w] = ~iv[w];
                av[w] = 16'h0033;
                bv[w] = 16'h0000;
            end
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(ovv[w]), 32'd1);
            checkOutput("hold_in_ready", 32'(ir[w]), 32'd0);
            checkOutput("hold_d", 32'(getD(w)), 32'(ed));
            checkOutput("hold_bout", 32'(bo[w]), 32'(eb));
            checkOutput("hold_ovf", 32'(of[w]), 32'(eo));
        end
        iv[w] = 1'b0;
        checkOutput("d", 32'(getD(w)), 32'(ed));
        checkOutput("bout", 32'(bo[w]), 32'(eb));
        checkOutput("ovf", 32'(of[w]), 32'(eo));
        orv[w] = 1'b1;
        @(posedge clk); #1;
        orv[w] = 1'b0;
        checkOutput("valid_drop", 32'(ovv[w]), 32'd0);
        checkOutput("in_ready_back", 32'(ir[w]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; av[i] = '0; bv[i] = '0; binv[i] = 1'b0; orv[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_out_valid", 32'(ovv[i]), 32'd0);
            checkOutput("rst_in_ready", 32'(ir[i]), 32'd1);
            checkOutput("rst_d", 32'(getD(i)), 32'd0);
            checkOutput("rst_bout", 32'(bo[i]), 32'd0);
            checkOutput("rst_ovf", 32'(of[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 16'h5A, 16'h3C, 1'b0, 0, 1'b0);
        applyStimulus(0, 16'h00, 16'h01, 1'b0, 0, 1'b0);
        applyStimulus(0, 16'h80, 16'h01, 1'b0, 1, 1'b0);
        applyStimulus(0, 16'h10, 16'h10, 1'b1, 0, 1'b0);
        applyStimulus(0, 16'hFF, 16'h00, 1'b1, 0, 1'b0);
        applyStimulus(0, 16'h81, 16'h42, 1'b0, 5, 1'b1);
        applyStimulus(0, 16'h44, 16'h11, 1'b1, 0, 1'b0);
        applyStimulus(1, 16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        applyStimulus(1, 16'h8000, 16'h0001, 1'b1, 2, 1'b0);

        // Abort an operation three slices in; it must never report a result.
        iv[0] = 1'b1; av[0] = 16'h00C3; bv[0] = 16'h0017; binv[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        orv[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abort_in_ready", 32'(ir[0]), 32'd1);
        checkOutput("abort_out_valid", 32'(ovv[0]), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_valid", 32'(ovv[0]), 32'd0);
        end
        orv[0] = 1'b0;
        applyStimulus(0, 16'h37, 16'hC8, 1'b1, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
